// File: rtl/riscv_pkg.sv
// Shared RV64 pipeline definitions: canonical NOP, default reset PC and fetch FSM encoding.
// Pure constants/types; no timing or flow-control behaviour of its own.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } if_state_t;

endpackage

// File: rtl/if_id_reg.sv
// One-entry IF/ID pipeline register (valid, instr, pc) with load, flush and hold.
// Updates one cycle after load/flush/consume; holds contents while valid and not consumed.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int PC_WIDTH = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [31:0]         load_instr,
  input  logic [PC_WIDTH-1:0] load_pc,
  input  logic                flush,
  input  logic                consume,
  output logic                valid,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] pc
);

  // Flush wins over a same-cycle load so a squashed fetch never becomes visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// RV64 instruction fetch: PC + single-outstanding fetch FSM feeding a one-entry IF/ID register.
// 1-cycle memory gives id_valid 2 cycles after acceptance; no request issues while decode stalls.
module if_stage
  import riscv_pkg::*;
#(
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT[PC_WIDTH-1:0]
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                id_valid,
  output logic [31:0]         id_instr,
  output logic [PC_WIDTH-1:0] id_pc,
  input  logic                id_ready
);

  if_state_t           state, state_nxt;
  logic [PC_WIDTH-1:0] pc, req_pc, redirect_tgt;
  logic                can_issue, accept, load;

  assign redirect_tgt = redirect_pc & ~{{(PC_WIDTH-2){1'b0}}, 2'b11};
  assign can_issue    = !id_valid || id_ready;
  assign imem_addr    = pc;

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    accept    = 1'b0;
    load      = 1'b0;
    case (state)
      S_REQ: begin
        imem_req = can_issue && !redirect_valid && !reset;
        accept   = imem_req && imem_ready;
        if (accept) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid) begin
          state_nxt = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          load      = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        // A response arriving alongside a further redirect still retires the
        // squashed fetch; waiting for another one would deadlock.
        if (imem_rvalid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        pc <= redirect_tgt;
      end else if (accept) begin
        pc <= pc + PC_WIDTH'(4);
      end
      if (accept) req_pc <= pc;
    end
  end

  if_id_reg #(
    .PC_WIDTH (PC_WIDTH)
  ) u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_instr (imem_rdata),
    .load_pc    (req_pc),
    .flush      (redirect_valid),
    .consume    (id_valid && id_ready),
    .valid      (id_valid),
    .instr      (id_instr),
    .pc         (id_pc)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed cycle table, reset-mid-fetch sequence, then random traffic vs a
// transaction-level model (pc, one outstanding fetch record, IF/ID queue of depth one).
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic        id_ready;

  int n_cmp = 0;
  int n_err = 0;

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        redir;
    logic [63:0] rpc;
    logic        idr;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_idv;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mk(logic redir, logic [63:0] rpc, logic idr, logic rdy, logic rv,
                              logic [31:0] rdata, logic e_req, logic [63:0] e_addr,
                              logic e_idv, logic [63:0] e_pc, logic [31:0] e_instr);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.idr = idr; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_idv = e_idv; v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  // Reference model state
  logic [63:0] m_pc;
  bit          m_out, m_live;
  logic [63:0] m_fpc;
  ent_t        m_idq[$];
  bit          mem_pend;
  int          mem_cnt;

  vec_t tbl[25];

  initial begin
    // redir rpc      idr rdy rv rdata          req addr     idv pc       instr
    tbl[0]  = mk(0, 64'h0,   1, 1, 0, 32'h0,        1, 64'h0,   0, 64'h0,   32'h0);
    tbl[1]  = mk(0, 64'h0,   0, 1, 1, 32'h00500093, 0, 64'h0,   0, 64'h0,   32'h0);
    tbl[2]  = mk(0, 64'h0,   0, 1, 0, 32'h0,        0, 64'h0,   1, 64'h0,   32'h00500093);
    tbl[3]  = mk(0, 64'h0,   0, 1, 0, 32'h0,        0, 64'h0,   1, 64'h0,   32'h00500093);
    tbl[4]  = mk(0, 64'h0,   0, 1, 0, 32'h0,        0, 64'h0,   1, 64'h0,   32'h00500093);
    tbl[5]  = mk(0, 64'h0,   1, 1, 0, 32'h0,        1, 64'h4,   1, 64'h0,   32'h00500093);
    tbl[6]  = mk(1, 64'h103, 1, 1, 0, 32'h0,        0, 64'h0,   0, 64'h0,   32'h0);
    tbl[7]  = mk(0, 64'h0,   1, 1, 1, 32'hdeadbeef, 0, 64'h0,   0, 64'h0,   32'h0);
    tbl[8]  = mk(0, 64'h0,   1, 1, 0, 32'h0,        1, 64'h100, 0, 64'h0,   32'h0);
    tbl[9]  = mk(0, 64'h0,   1, 1, 1, 32'h00208033, 0, 64'h0,   0, 64'h0,   32'h0);
    tbl[10] = mk(0, 64'h0,   1, 1, 0, 32'h0,        1, 64'h104, 1, 64'h100, 32'h00208033);
    tbl[11] = mk(1, 64'h00a, 1, 1, 1, 32'hfe000ce3, 0, 64'h0,   0, 64'h0,   32'h0);
    tbl[12] = mk(0, 64'h0,   1, 0, 0, 32'h0,        1, 64'h8,   0, 64'h0,   32'h0);
    tbl[13] = mk(0, 64'h0,   1, 0, 0, 32'h0,        1, 64'h8,   0, 64'h0,   32'h0);
    tbl[14] = mk(0, 64'h0,   1, 0, 0, 32'h0,        1, 64'h8,   0, 64'h0,   32'h0);
    tbl[15] = mk(0, 64'h0,   1, 0, 0, 32'h0,        1, 64'h8,   0, 64'h0,   32'h0);
    tbl[16] = mk(0, 64'h0,   1, 1, 0, 32'h0,        1, 64'h8,   0, 64'h0,   32'h0);
    tbl[17] = mk(0, 64'h0,   1, 1, 0, 32'h0,        0, 64'h0,   0, 64'h0,   32'h0);
    tbl[18] = mk(0, 64'h0,   1, 1, 1, 32'h00c00193, 0, 64'h0,   0, 64'h0,   32'h0);
    tbl[19] = mk(0, 64'h0,   1, 0, 0, 32'h0,        1, 64'hc,   1, 64'h8,   32'h00c00193);
    tbl[20] = mk(0, 64'h0,   1, 0, 0, 32'h0,        1, 64'hc,   0, 64'h0,   32'h0);
    tbl[21] = mk(1, 64'h40,  1, 1, 0, 32'h0,        0, 64'h0,   0, 64'h0,   32'h0);
    tbl[22] = mk(0, 64'h0,   1, 1, 0, 32'h0,        1, 64'h40,  0, 64'h0,   32'h0);
    tbl[23] = mk(0, 64'h0,   1, 1, 1, 32'h12345678, 0, 64'h0,   0, 64'h0,   32'h0);
    tbl[24] = mk(0, 64'h0,   1, 0, 0, 32'h0,        1, 64'h44,  1, 64'h40,  32'h12345678);

    reset = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    #3;
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_idv", {63'd0, id_valid}, 64'd0);
    chk("rst_instr", {32'd0, id_instr}, 64'h13);
    chk("rst_pc", id_pc, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      redirect_valid = tbl[i].redir; redirect_pc = tbl[i].rpc; id_ready = tbl[i].idr;
      imem_ready = tbl[i].rdy; imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rdata;
      #1;
      chk($sformatf("row%0d_req", i), {63'd0, imem_req}, {63'd0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("row%0d_idv", i), {63'd0, id_valid}, {63'd0, tbl[i].e_idv});
      if (tbl[i].e_idv) begin
        chk($sformatf("row%0d_idpc", i), id_pc, tbl[i].e_pc);
        chk($sformatf("row%0d_instr", i), {32'd0, id_instr}, {32'd0, tbl[i].e_instr});
      end
      if (i >= 12 && i <= 18)
        chk($sformatf("row%0d_nodrop", i), {63'd0, id_instr == 32'hfe000ce3}, 64'd0);
    end

    // Reset asserted while a fetch to 0x44 is in flight, then a stray response.
    @(negedge clk);
    redirect_valid = 1'b0; id_ready = 1'b1; imem_ready = 1'b1; imem_rvalid = 1'b0;
    #1;
    chk("t6_req", {63'd0, imem_req}, 64'd1);
    chk("t6_addr", imem_addr, 64'h44);
    @(negedge clk);
    imem_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_idv", {63'd0, id_valid}, 64'd0);
    chk("t6_rst_instr", {32'd0, id_instr}, 64'h13);
    chk("t6_rst_pc", id_pc, 64'd0);
    chk("t6_rst_req", {63'd0, imem_req}, 64'd0);
    @(negedge clk);
    reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0badbad0;
    #1;
    chk("t6_stray_req", {63'd0, imem_req}, 64'd1);
    chk("t6_stray_addr", imem_addr, 64'h0);
    @(negedge clk);
    imem_rvalid = 1'b0; imem_ready = 1'b1;
    #1;
    chk("t6_idv_after_stray", {63'd0, id_valid}, 64'd0);
    chk("t6_first_addr", imem_addr, 64'h0);
    chk("t6_first_req", {63'd0, imem_req}, 64'd1);
    @(negedge clk);
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00100073; id_ready = 1'b0;
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1;
    chk("t6_load_idv", {63'd0, id_valid}, 64'd1);
    chk("t6_load_pc", id_pc, 64'h0);
    chk("t6_load_instr", {32'd0, id_instr}, 64'h00100073);

    // Random traffic against the transaction-level model.
    @(negedge clk);
    reset = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0; id_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_pc = 64'h0; m_out = 0; m_live = 0; m_fpc = '0; m_idq.delete();
    mem_pend = 0; mem_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      bit   exp_req, acc, got;
      ent_t e;
      @(negedge clk);
      imem_rvalid    = mem_pend && (mem_cnt == 0);
      imem_rdata     = $urandom;
      imem_ready     = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = {$urandom, $urandom};
      #1;
      exp_req = !m_out && (m_idq.size() == 0 || id_ready) && !redirect_valid;
      chk($sformatf("rnd%0d_req", c), {63'd0, imem_req}, {63'd0, exp_req});
      if (exp_req) chk($sformatf("rnd%0d_addr", c), imem_addr, m_pc);
      chk($sformatf("rnd%0d_idv", c), {63'd0, id_valid}, {63'd0, m_idq.size() != 0});
      if (m_idq.size() != 0) begin
        chk($sformatf("rnd%0d_idpc", c), id_pc, m_idq[0].pc);
        chk($sformatf("rnd%0d_instr", c), {32'd0, id_instr}, {32'd0, m_idq[0].instr});
      end
      // memory responder follows the DUT's actual handshake
      if (imem_rvalid) mem_pend = 0;
      else if (mem_pend && mem_cnt > 0) mem_cnt--;
      if (imem_req && imem_ready) begin
        mem_pend = 1;
        mem_cnt  = $urandom_range(0, 2);
      end
      // model update for the coming edge
      acc = exp_req && imem_ready;
      got = imem_rvalid && m_out;
      if (m_idq.size() != 0 && id_ready) m_idq.delete();
      if (got && m_live && !redirect_valid) begin
        e.instr = imem_rdata;
        e.pc    = m_fpc;
        m_idq.push_back(e);
      end
      if (got) m_out = 0;
      if (acc) begin
        m_out  = 1;
        m_live = 1;
        m_fpc  = m_pc;
        m_pc   = m_pc + 64'd4;
      end
      if (redirect_valid) begin
        m_pc = {redirect_pc[63:2], 2'b00};
        m_idq.delete();
        if (m_out) m_live = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
